// File: rtl/register_file.sv
// register_file: 16x16 CPU register file, 2 async read ports, 1 sync write port, reg0 tied to zero.
// Latency: reads combinational; writes and the one-shot ARGUMENT load visible after 1 CLK edge.
// Backpressure: none, a write is accepted every cycle. Optional REGFILE_BYPASS_EN forwards write data to reads.
module register_file #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ARG_REG  = 1,
    parameter int DISP_REG = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] r1A,
    input  logic [ADDR_W-1:0] r2A,
    input  logic [ADDR_W-1:0] WA,
    input  logic              RW,
    input  logic [DATA_W-1:0] RWD,
    input  logic [DATA_W-1:0] ARGUMENT,
    output logic [DATA_W-1:0] r1D,
    output logic [DATA_W-1:0] r2D,
    output logic [DATA_W-1:0] DISPLAY
);

    localparam int                NREGS  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ARG_A  = ADDR_W'(ARG_REG);
    localparam logic [ADDR_W-1:0] DISP_A = ADDR_W'(DISP_REG);

    logic [DATA_W-1:0] regs [NREGS];
    logic              arg_pending;
    logic              wr_en;

    // The pending argument load owns ARG_REG on its edge, so a colliding write is dropped.
    assign wr_en = RW && (WA != '0) && !(arg_pending && (WA == ARG_A));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            arg_pending <= 1'b1;
        end else begin
            if (arg_pending) begin
                regs[ARG_A] <= ARGUMENT;
                arg_pending <= 1'b0;
            end
            if (wr_en) begin
                regs[WA] <= RWD;
            end
        end
    end

    logic [DATA_W-1:0] r1_q, r2_q, disp_q;

    assign r1_q   = (r1A == '0) ? '0 : regs[r1A];
    assign r2_q   = (r2A == '0) ? '0 : regs[r2A];
    assign disp_q = regs[DISP_A];

`ifdef REGFILE_BYPASS_EN
    logic fwd_arg, fwd_wr;

    // Argument forwarding takes priority, mirroring the storage priority above.
    assign fwd_arg = RESET && arg_pending;
    assign fwd_wr  = RESET && RW && (WA != '0);

    assign r1D     = (fwd_arg && (r1A == ARG_A))    ? ARGUMENT :
                     (fwd_wr  && (r1A == WA))       ? RWD      : r1_q;
    assign r2D     = (fwd_arg && (r2A == ARG_A))    ? ARGUMENT :
                     (fwd_wr  && (r2A == WA))       ? RWD      : r2_q;
    assign DISPLAY = (fwd_arg && (DISP_A == ARG_A)) ? ARGUMENT :
                     (fwd_wr  && (DISP_A == WA))    ? RWD      : disp_q;
`else
    assign r1D     = r1_q;
    assign r2D     = r2_q;
    assign DISPLAY = disp_q;
`endif

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the read ports and DISPLAY.
module tb_register_file;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  r1A, r2A, WA;
    logic        RW;
    logic [15:0] RWD, ARGUMENT;
    logic [15:0] r1D, r2D, DISPLAY;

    register_file dut (
        .CLK(CLK), .RESET(RESET), .r1A(r1A), .r2A(r2A), .WA(WA), .RW(RW),
        .RWD(RWD), .ARGUMENT(ARGUMENT), .r1D(r1D), .r2D(r2D), .DISPLAY(DISPLAY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        int          sel;   // 0: r1D, 1: r2D, 2: DISPLAY
        logic [15:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_val(input string nm, input int sel, input logic [15:0] v);
        exp_t e;
        e.name = nm;
        e.sel  = sel;
        e.exp  = v;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: values are stable mid-cycle, away from the rising edge.
    always @(negedge CLK) begin
        while (sbq.size() > 0) begin
            exp_t        e;
            logic [15:0] act;
            e = sbq.pop_front();
            case (e.sel)
                0:       act = r1D;
                1:       act = r2D;
                default: act = DISPLAY;
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        RESET = 1'b0; ARGUMENT = 16'h1234;
        r1A = '0; r2A = '0; WA = '0; RW = 1'b0; RWD = '0;

        // Reset state
        tick();
        r1A = 4'd1; r2A = 4'd15;
        expect_val("rst_r1", 0, 16'h0000);
        expect_val("rst_r2", 1, 16'h0000);
        expect_val("rst_disp", 2, 16'h0000);
        tick();

        // Release: first edge loads reg1, second edge must not reload
        RESET = 1'b1;
        tick();
        ARGUMENT = 16'h9999;
        expect_val("arg_load", 0, 16'h1234);
        tick();
        expect_val("arg_once", 0, 16'h1234);
        tick();

        // Pulsed write sweep
        for (int k = 1; k < 16; k++) begin
            RW = 1'b1; WA = 4'(k); RWD = 16'(k);
            tick();
            RW = 1'b0;
            tick();
        end
        for (int k = 1; k < 16; k++) begin
            r1A = 4'(k); r2A = 4'(16 - k);
            expect_val($sformatf("sweep_r1_%0d", k), 0, 16'(k));
            expect_val($sformatf("sweep_r2_%0d", 16 - k), 1, 16'(16 - k));
            tick();
        end
        expect_val("sweep_disp", 2, 16'h000F);

        // Continuous write, RW held high: reg[k] = k * 0x1111
        RW = 1'b1;
        for (int k = 1; k < 16; k++) begin
            WA = 4'(k); RWD = 16'(k) * 16'h1111;
            tick();
        end
        RW = 1'b0; WA = 4'd3; RWD = 16'h0000;
        tick();
        tick();
        for (int k = 1; k < 16; k++) begin
            r1A = 4'(k);
            expect_val($sformatf("cont_r1_%0d", k), 0, 16'(k) * 16'h1111);
            tick();
        end
        expect_val("cont_disp", 2, 16'hFFFF);

        // Register zero ignores writes
        RW = 1'b1; WA = 4'd0; RWD = 16'hFFFF;
        tick();
        RW = 1'b0; r1A = 4'd0; r2A = 4'd0;
        expect_val("zero_r1", 0, 16'h0000);
        expect_val("zero_r2", 1, 16'h0000);
        tick();

        // Write collision on reg7 and on the display register
        RW = 1'b1; WA = 4'd7; RWD = 16'h0010; r1A = 4'd7; r2A = 4'd7;
`ifdef REGFILE_BYPASS_EN
        expect_val("coll_pre_r1", 0, 16'h0010);
        expect_val("coll_pre_r2", 1, 16'h0010);
`else
        expect_val("coll_pre_r1", 0, 16'h7777);
        expect_val("coll_pre_r2", 1, 16'h7777);
`endif
        tick();
        RW = 1'b0;
        expect_val("coll_post_r1", 0, 16'h0010);
        tick();
        RW = 1'b1; WA = 4'd15; RWD = 16'h00AB;
`ifdef REGFILE_BYPASS_EN
        expect_val("disp_pre", 2, 16'h00AB);
`else
        expect_val("disp_pre", 2, 16'hFFFF);
`endif
        tick();
        RW = 1'b0;
        expect_val("disp_post", 2, 16'h00AB);
        tick();

        // Mid-operation reset clears immediately; argument beats colliding write
        RESET = 1'b0; r1A = 4'd7; r2A = 4'd1;
        expect_val("mid_rst_r1", 0, 16'h0000);
        expect_val("mid_rst_r2", 1, 16'h0000);
        expect_val("mid_rst_disp", 2, 16'h0000);
        tick();
        RESET = 1'b1; ARGUMENT = 16'h5555;
        RW = 1'b1; WA = 4'd1; RWD = 16'hAAAA; r1A = 4'd1;
`ifdef REGFILE_BYPASS_EN
        expect_val("argcoll_pre", 0, 16'h5555);
`else
        expect_val("argcoll_pre", 0, 16'h0000);
`endif
        tick();
        RW = 1'b0; r2A = 4'd7;
        expect_val("argcoll_post", 0, 16'h5555);
        expect_val("argcoll_r7", 1, 16'h0000);
        tick();

        // Write to another address on the load edge proceeds
        RESET = 1'b0;
        tick();
        RESET = 1'b1; ARGUMENT = 16'h0A0A;
        RW = 1'b1; WA = 4'd5; RWD = 16'h0505;
        tick();
        RW = 1'b0; r1A = 4'd1; r2A = 4'd5;
        expect_val("argother_r1", 0, 16'h0A0A);
        expect_val("argother_r5", 1, 16'h0505);
        tick();

        // Drain with a bounded wait
        for (int i = 0; i < 4 && sbq.size() > 0; i++) tick();
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
